// File: rtl/tmds_decode.sv
// TMDS receive-side symbol decoder: undoes DC-balance inversion and XOR/XNOR
// transition coding, classifies control tokens and drives a bit-slip lock FSM.
module tmds_decode #(
    parameter int LOCK_COUNT     = 4,
    parameter int SEARCH_TIMEOUT = 1024
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       symbol_valid_in,
    input  logic [9:0] symbol_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked_out,
    output logic       bitslip_out,
    output logic [7:0] loss_count_out
);
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, run_inc;
    logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
    logic [7:0]        loss_q, loss_d;
    logic              slip_d;

    logic [7:0] data_q, data_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       de_q, de_d;
    logic       valid_q;
    logic       slip_q;

    logic       is_tok;
    logic [1:0] tok_val;
    logic [7:0] d_raw;
    logic [7:0] dec;

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (symbol_in)
            10'h354: tok_val = 2'b00;
            10'h0AB: tok_val = 2'b01;
            10'h154: tok_val = 2'b10;
            10'h2AB: tok_val = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // Inversion first, then unwind the chained XOR/XNOR from bit 0 upward.
    always_comb begin
        dec    = '0;
        d_raw  = symbol_in[9] ? ~symbol_in[7:0] : symbol_in[7:0];
        dec[0] = d_raw[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = symbol_in[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        idle_d   = idle_q;
        loss_d   = loss_q;
        slip_d   = 1'b0;
        run_inc  = (run_q == RUN_W'(LOCK_COUNT)) ? run_q : run_q + 1'b1;
        idle_inc = idle_q + 1'b1;
        if (symbol_valid_in) begin
            case (state_q)
                SEARCH: begin
                    if (is_tok && run_inc == RUN_W'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        run_d   = run_inc;
                        idle_d  = '0;
                    end else if (idle_inc == IDLE_W'(SEARCH_TIMEOUT)) begin
                        slip_d = 1'b1;
                        idle_d = '0;
                        run_d  = '0;
                    end else begin
                        idle_d = idle_inc;
                        run_d  = is_tok ? run_inc : '0;
                    end
                end
                default: begin
                    if (is_tok) begin
                        idle_d = '0;
                    end else if (idle_inc == IDLE_W'(SEARCH_TIMEOUT)) begin
                        state_d = SEARCH;
                        run_d   = '0;
                        idle_d  = '0;
                        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 1'b1;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        de_d   = de_q;
        if (symbol_valid_in) begin
            data_d = is_tok ? 8'h00 : dec;
            de_d   = ~is_tok;
            if (is_tok) ctrl_d = tok_val;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= SEARCH;
            run_q   <= '0;
            idle_q  <= '0;
            loss_q  <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            de_q    <= 1'b0;
            valid_q <= 1'b0;
            slip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            idle_q  <= idle_d;
            loss_q  <= loss_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            de_q    <= de_d;
            valid_q <= symbol_valid_in && (state_d == LOCKED);
            slip_q  <= slip_d;
        end
    end

    assign data_out       = data_q;
    assign ctrl_out       = ctrl_q;
    assign de_out         = de_q;
    assign valid_out      = valid_q;
    assign locked_out     = (state_q == LOCKED);
    assign bitslip_out    = slip_q;
    assign loss_count_out = loss_q;
endmodule

// File: tb/tb_tmds_decode.sv
// Directed bench for tmds_decode: a vector table for decode/token behaviour
// plus hand-written sequences for slip, loss-of-lock and async reset.
module tb_tmds_decode;
    logic       clk;
    logic       rst_n;
    logic       sym_valid;
    logic [9:0] sym;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       valid_out;
    logic       locked_out;
    logic       bitslip_out;
    logic [7:0] loss_count_out;

    int n_vec  = 0;
    int n_fail = 0;

    tmds_decode dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .symbol_valid_in(sym_valid),
        .symbol_in      (sym),
        .data_out       (data_out),
        .ctrl_out       (ctrl_out),
        .de_out         (de_out),
        .valid_out      (valid_out),
        .locked_out     (locked_out),
        .bitslip_out    (bitslip_out),
        .loss_count_out (loss_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [9:0] sym;
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_ctrl;
        logic       e_de;
        logic       e_lock;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [9:0] s, input logic ev,
                           input logic [7:0] ed, input logic [1:0] ec,
                           input logic ede, input logic el);
        vec_t t;
        t.vld = v; t.sym = s; t.e_valid = ev; t.e_data = ed;
        t.e_ctrl = ec; t.e_de = ede; t.e_lock = el;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [9:0] s);
        @(negedge clk);
        sym_valid = v;
        sym       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym       = 10'h000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".data"},  {24'd0, data_out}, 32'd0);
        chk({tag, ".ctrl"},  {30'd0, ctrl_out}, 32'd0);
        chk({tag, ".de"},    {31'd0, de_out}, 32'd0);
        chk({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
        chk({tag, ".lock"},  {31'd0, locked_out}, 32'd0);
        chk({tag, ".slip"},  {31'd0, bitslip_out}, 32'd0);
        chk({tag, ".loss"},  {24'd0, loss_count_out}, 32'd0);
    endtask

    task automatic lock_up(input logic [9:0] tok);
        for (int i = 0; i < 4; i++) apply(1'b1, tok);
    endtask

    initial begin
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym       = 10'h000;
        #12;
        check_all_zero("reset");
        do_reset();

        // Lock on four 354 tokens, then decode a data/token mix.
        add_vec(1, 10'h354, 0, 8'h00, 2'b00, 0, 0);
        add_vec(1, 10'h354, 0, 8'h00, 2'b00, 0, 0);
        add_vec(1, 10'h354, 0, 8'h00, 2'b00, 0, 0);
        add_vec(1, 10'h354, 1, 8'h00, 2'b00, 0, 1);
        add_vec(1, 10'h0AB, 1, 8'h00, 2'b01, 0, 1);
        add_vec(1, 10'h100, 1, 8'h00, 2'b01, 1, 1);
        add_vec(1, 10'h0FF, 1, 8'hFF, 2'b01, 1, 1);
        add_vec(1, 10'h2FF, 1, 8'hFE, 2'b01, 1, 1);
        add_vec(0, 10'h0FF, 0, 8'hFE, 2'b01, 1, 1);
        add_vec(1, 10'h154, 1, 8'h00, 2'b10, 0, 1);
        add_vec(1, 10'h055, 1, 8'h01, 2'b10, 1, 1);
        add_vec(1, 10'h3AA, 1, 8'hFF, 2'b10, 1, 1);
        add_vec(1, 10'h355, 1, 8'hFE, 2'b10, 1, 1);
        add_vec(1, 10'h2AB, 1, 8'h00, 2'b11, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].vld, vecs[i].sym);
            chk($sformatf("vec%0d.valid", i), {31'd0, valid_out},  {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d.data", i),  {24'd0, data_out},   {24'd0, vecs[i].e_data});
            chk($sformatf("vec%0d.ctrl", i),  {30'd0, ctrl_out},   {30'd0, vecs[i].e_ctrl});
            chk($sformatf("vec%0d.de", i),    {31'd0, de_out},     {31'd0, vecs[i].e_de});
            chk($sformatf("vec%0d.lock", i),  {31'd0, locked_out}, {31'd0, vecs[i].e_lock});
            chk($sformatf("vec%0d.slip", i),  {31'd0, bitslip_out}, 32'd0);
        end

        // 2048 data symbols from reset: slips after the 1024th and 2048th only.
        do_reset();
        for (int k = 1; k <= 2048; k++) begin
            apply(1'b1, 10'h100);
            chk($sformatf("slip.k%0d", k), {31'd0, bitslip_out},
                {31'd0, (k == 1024 || k == 2048)});
            if (k % 256 == 0 || k == 1024 || k == 1025) begin
                chk($sformatf("slip.lock.k%0d", k),  {31'd0, locked_out}, 32'd0);
                chk($sformatf("slip.valid.k%0d", k), {31'd0, valid_out}, 32'd0);
            end
        end

        // Interrupted token run must not lock; a fresh run of four does.
        do_reset();
        for (int i = 0; i < 3; i++) apply(1'b1, 10'h0AB);
        chk("run3.lock", {31'd0, locked_out}, 32'd0);
        chk("run3.ctrl", {30'd0, ctrl_out}, 32'd1);
        apply(1'b1, 10'h100);
        chk("brk.lock", {31'd0, locked_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 10'h2AB);
            chk($sformatf("run4.t%0d.lock", i), {31'd0, locked_out}, 32'd0);
            chk($sformatf("run4.t%0d.valid", i), {31'd0, valid_out}, 32'd0);
        end
        apply(1'b1, 10'h2AB);
        chk("run4.lock",  {31'd0, locked_out}, 32'd1);
        chk("run4.valid", {31'd0, valid_out}, 32'd1);
        chk("run4.ctrl",  {30'd0, ctrl_out}, 32'd3);

        // Loss of lock after 1024 token-free symbols; idle cycles do not count.
        for (int k = 1; k <= 1024; k++) begin
            apply(1'b1, 10'h100);
            if (k < 1024) begin
                chk($sformatf("loss.lock.k%0d", k), {31'd0, locked_out}, 32'd1);
            end else begin
                chk("loss.lock.end",  {31'd0, locked_out}, 32'd0);
                chk("loss.valid.end", {31'd0, valid_out}, 32'd0);
                chk("loss.count.end", {24'd0, loss_count_out}, 32'd1);
            end
            chk($sformatf("loss.slip.k%0d", k), {31'd0, bitslip_out}, 32'd0);
            if (k % 100 == 0) begin
                apply(1'b0, 10'h100);
                chk($sformatf("gap.lock.k%0d", k),  {31'd0, locked_out}, 32'd1);
                chk($sformatf("gap.valid.k%0d", k), {31'd0, valid_out}, 32'd0);
                chk($sformatf("gap.loss.k%0d", k),  {24'd0, loss_count_out}, 32'd0);
            end
        end
        apply(1'b0, 10'h354);
        chk("loss.hold", {24'd0, loss_count_out}, 32'd1);

        // Mid-stream asynchronous reset clears everything before the next edge.
        lock_up(10'h154);
        apply(1'b1, 10'h0FF);
        chk("pre_rst.lock", {31'd0, locked_out}, 32'd1);
        chk("pre_rst.data", {24'd0, data_out}, 32'hFF);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        sym_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 10'h354);
            chk($sformatf("relock.t%0d", i), {31'd0, locked_out}, 32'd0);
        end
        apply(1'b1, 10'h354);
        chk("relock.lock",  {31'd0, locked_out}, 32'd1);
        chk("relock.valid", {31'd0, valid_out}, 32'd1);
        chk("relock.loss",  {24'd0, loss_count_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
